// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
//
// Holds non-memory instructions from the issue stage until both source
// operands are known. It snoops the ALU and LSB result buses to capture
// operands, and each cycle sends the lowest-index ready entry to the ALU as a
// registered one-cycle pulse.
//
// Ports:
//   clk_in, rst_n_in        clock (rising edge), async active-low reset
//   rdy_in                  global ready; when low all state holds
//   rollback                misprediction flush, clears every entry
//   issue_*                 insert request bundle from the issue stage
//   rs_full                 stall request back to issue (one slot of margin)
//   alu_cdb_*, lsb_cdb_*    result broadcasts used for operand wakeup
//   exec_*                  registered dispatch bundle to the ALU
// -----------------------------------------------------------------------------
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int RS_LOG  = 4,
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               rdy_in,
    input  logic               rollback,
    input  logic               issue_enable,
    input  logic [OP_LOG-1:0]  issue_op,
    input  logic [31:0]        issue_Vj,
    input  logic [31:0]        issue_Vk,
    input  logic               issue_Rj,
    input  logic               issue_Rk,
    input  logic [ROB_LOG-1:0] issue_Qj,
    input  logic [ROB_LOG-1:0] issue_Qk,
    input  logic [31:0]        issue_Imm,
    input  logic [31:0]        issue_CurPc,
    input  logic [ROB_LOG-1:0] issue_RobId,
    output logic               rs_full,
    input  logic               alu_cdb_valid,
    input  logic [ROB_LOG-1:0] alu_cdb_RobId,
    input  logic [31:0]        alu_cdb_value,
    input  logic               lsb_cdb_valid,
    input  logic [ROB_LOG-1:0] lsb_cdb_RobId,
    input  logic [31:0]        lsb_cdb_value,
    output logic               exec_valid,
    output logic [OP_LOG-1:0]  exec_op,
    output logic [31:0]        exec_Vj,
    output logic [31:0]        exec_Vk,
    output logic [31:0]        exec_Imm,
    output logic [31:0]        exec_CurPc,
    output logic [ROB_LOG-1:0] exec_RobId
);

    localparam int              FULL_LVL_I = RS_SIZE - 1;
    localparam logic [RS_LOG:0] FULL_LVL   = FULL_LVL_I[RS_LOG:0];

    // Returns {found, index} of the lowest set bit of vec.
    function automatic logic [RS_LOG:0] find_lowest(input logic [RS_SIZE-1:0] vec);
        logic [RS_LOG:0] res;
        res = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, RS_LOG'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Returns {ready, value} for one operand after looking at both result
    // buses. The ALU bus is checked first; the two never carry equal tags.
    function automatic logic [32:0] snoop(
        input logic               op_rdy,
        input logic [ROB_LOG-1:0] op_tag,
        input logic [31:0]        op_val,
        input logic               a_vld,
        input logic [ROB_LOG-1:0] a_tag,
        input logic [31:0]        a_val,
        input logic               l_vld,
        input logic [ROB_LOG-1:0] l_tag,
        input logic [31:0]        l_val
    );
        logic [32:0] res;
        if (op_rdy) begin
            res = {1'b1, op_val};
        end else if (a_vld && (a_tag == op_tag)) begin
            res = {1'b1, a_val};
        end else if (l_vld && (l_tag == op_tag)) begin
            res = {1'b1, l_val};
        end else begin
            res = {1'b0, op_val};
        end
        return res;
    endfunction

    // Entry state
    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] rj_q, rj_d;
    logic [RS_SIZE-1:0] rk_q, rk_d;
    logic [OP_LOG-1:0]  op_q  [RS_SIZE];
    logic [OP_LOG-1:0]  op_d  [RS_SIZE];
    logic [31:0]        vj_q  [RS_SIZE];
    logic [31:0]        vj_d  [RS_SIZE];
    logic [31:0]        vk_q  [RS_SIZE];
    logic [31:0]        vk_d  [RS_SIZE];
    logic [ROB_LOG-1:0] qj_q  [RS_SIZE];
    logic [ROB_LOG-1:0] qj_d  [RS_SIZE];
    logic [ROB_LOG-1:0] qk_q  [RS_SIZE];
    logic [ROB_LOG-1:0] qk_d  [RS_SIZE];
    logic [31:0]        imm_q [RS_SIZE];
    logic [31:0]        imm_d [RS_SIZE];
    logic [31:0]        pc_q  [RS_SIZE];
    logic [31:0]        pc_d  [RS_SIZE];
    logic [ROB_LOG-1:0] rob_q [RS_SIZE];
    logic [ROB_LOG-1:0] rob_d [RS_SIZE];

    // Dispatch output registers
    logic               exec_valid_q, exec_valid_d;
    logic [OP_LOG-1:0]  exec_op_q, exec_op_d;
    logic [31:0]        exec_vj_q, exec_vj_d;
    logic [31:0]        exec_vk_q, exec_vk_d;
    logic [31:0]        exec_imm_q, exec_imm_d;
    logic [31:0]        exec_pc_q, exec_pc_d;
    logic [ROB_LOG-1:0] exec_rob_q, exec_rob_d;

    // Selection and occupancy
    logic [RS_SIZE-1:0] ready_s;
    logic [RS_LOG:0]    disp_sel_s;
    logic [RS_LOG:0]    ins_sel_s;
    logic               disp_found_s;
    logic               ins_found_s;
    logic [RS_LOG-1:0]  disp_idx_s;
    logic [RS_LOG-1:0]  ins_idx_s;
    logic [RS_LOG:0]    busy_cnt_s;

    // Readiness is taken from registered state only, so an entry inserted or
    // woken at an edge is dispatched no earlier than the following edge.
    // The insert slot comes from the pre-edge busy vector: a slot being
    // dispatched this edge still counts as occupied.
    assign ready_s      = busy_q & rj_q & rk_q;
    assign disp_sel_s   = find_lowest(ready_s);
    assign ins_sel_s    = find_lowest(~busy_q);
    assign disp_found_s = disp_sel_s[RS_LOG];
    assign disp_idx_s   = disp_sel_s[RS_LOG-1:0];
    assign ins_found_s  = ins_sel_s[RS_LOG];
    assign ins_idx_s    = ins_sel_s[RS_LOG-1:0];

    // Population count of busy entries for the stall flag.
    always_comb begin
        busy_cnt_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_cnt_s = busy_cnt_s + {{RS_LOG{1'b0}}, busy_q[i]};
        end
    end

    // Stall one slot early so the instruction already in issue still fits.
    assign rs_full = (busy_cnt_s >= FULL_LVL);

    // Next-state: rollback, else wakeup + dispatch + insert together.
    always_comb begin
        busy_d       = busy_q;
        rj_d         = rj_q;
        rk_d         = rk_q;
        op_d         = op_q;
        vj_d         = vj_q;
        vk_d         = vk_q;
        qj_d         = qj_q;
        qk_d         = qk_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        rob_d        = rob_q;
        exec_valid_d = 1'b0;
        exec_op_d    = exec_op_q;
        exec_vj_d    = exec_vj_q;
        exec_vk_d    = exec_vk_q;
        exec_imm_d   = exec_imm_q;
        exec_pc_d    = exec_pc_q;
        exec_rob_d   = exec_rob_q;

        if (rollback) begin
            // Flush: drop every entry and any concurrent insert.
            busy_d = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i]) begin
                    {rj_d[i], vj_d[i]} = snoop(rj_q[i], qj_q[i], vj_q[i],
                                               alu_cdb_valid, alu_cdb_RobId, alu_cdb_value,
                                               lsb_cdb_valid, lsb_cdb_RobId, lsb_cdb_value);
                    {rk_d[i], vk_d[i]} = snoop(rk_q[i], qk_q[i], vk_q[i],
                                               alu_cdb_valid, alu_cdb_RobId, alu_cdb_value,
                                               lsb_cdb_valid, lsb_cdb_RobId, lsb_cdb_value);
                end else begin
                    rj_d[i] = rj_q[i];
                    rk_d[i] = rk_q[i];
                end
            end

            if (disp_found_s) begin
                exec_valid_d       = 1'b1;
                exec_op_d          = op_q[disp_idx_s];
                exec_vj_d          = vj_q[disp_idx_s];
                exec_vk_d          = vk_q[disp_idx_s];
                exec_imm_d         = imm_q[disp_idx_s];
                exec_pc_d          = pc_q[disp_idx_s];
                exec_rob_d         = rob_q[disp_idx_s];
                busy_d[disp_idx_s] = 1'b0;
            end else begin
                exec_valid_d = 1'b0;
            end

            // An insert with no free slot cannot happen while issue honours
            // rs_full; if it does, the request is dropped.
            if (issue_enable && ins_found_s) begin
                busy_d[ins_idx_s] = 1'b1;
                op_d[ins_idx_s]   = issue_op;
                qj_d[ins_idx_s]   = issue_Qj;
                qk_d[ins_idx_s]   = issue_Qk;
                imm_d[ins_idx_s]  = issue_Imm;
                pc_d[ins_idx_s]   = issue_CurPc;
                rob_d[ins_idx_s]  = issue_RobId;
                {rj_d[ins_idx_s], vj_d[ins_idx_s]} =
                    snoop(issue_Rj, issue_Qj, issue_Vj,
                          alu_cdb_valid, alu_cdb_RobId, alu_cdb_value,
                          lsb_cdb_valid, lsb_cdb_RobId, lsb_cdb_value);
                {rk_d[ins_idx_s], vk_d[ins_idx_s]} =
                    snoop(issue_Rk, issue_Qk, issue_Vk,
                          alu_cdb_valid, alu_cdb_RobId, alu_cdb_value,
                          lsb_cdb_valid, lsb_cdb_RobId, lsb_cdb_value);
            end else begin
            end
        end
    end

    // Entry storage; holds while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            rj_q   <= '0;
            rk_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
                rob_q[i] <= '0;
            end
        end else if (rdy_in) begin
            busy_q <= busy_d;
            rj_q   <= rj_d;
            rk_q   <= rk_d;
            op_q   <= op_d;
            vj_q   <= vj_d;
            vk_q   <= vk_d;
            qj_q   <= qj_d;
            qk_q   <= qk_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            rob_q  <= rob_d;
        end
    end

    // Dispatch registers; exec_valid holds its value while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            exec_valid_q <= 1'b0;
            exec_op_q    <= '0;
            exec_vj_q    <= 32'h0000_0000;
            exec_vk_q    <= 32'h0000_0000;
            exec_imm_q   <= 32'h0000_0000;
            exec_pc_q    <= 32'h0000_0000;
            exec_rob_q   <= '0;
        end else if (rdy_in) begin
            exec_valid_q <= exec_valid_d;
            exec_op_q    <= exec_op_d;
            exec_vj_q    <= exec_vj_d;
            exec_vk_q    <= exec_vk_d;
            exec_imm_q   <= exec_imm_d;
            exec_pc_q    <= exec_pc_d;
            exec_rob_q   <= exec_rob_d;
        end
    end

    assign exec_valid = exec_valid_q;
    assign exec_op    = exec_op_q;
    assign exec_Vj    = exec_vj_q;
    assign exec_Vk    = exec_vk_q;
    assign exec_Imm   = exec_imm_q;
    assign exec_CurPc = exec_pc_q;
    assign exec_RobId = exec_rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
//
// Table of per-cycle vectors (inputs applied before an edge, expected dispatch
// outputs sampled 1 time unit after it), followed by hand-written sequences
// for fill/ordering, rollback, rdy_in hold and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        rollback;
    logic        issue_enable;
    logic [5:0]  issue_op;
    logic [31:0] issue_Vj, issue_Vk;
    logic        issue_Rj, issue_Rk;
    logic [3:0]  issue_Qj, issue_Qk;
    logic [31:0] issue_Imm, issue_CurPc;
    logic [3:0]  issue_RobId;
    logic        rs_full;
    logic        alu_cdb_valid;
    logic [3:0]  alu_cdb_RobId;
    logic [31:0] alu_cdb_value;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_RobId;
    logic [31:0] lsb_cdb_value;
    logic        exec_valid;
    logic [5:0]  exec_op;
    logic [31:0] exec_Vj, exec_Vk, exec_Imm, exec_CurPc;
    logic [3:0]  exec_RobId;

    int checks = 0;
    int errors = 0;

    reservation_station dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rollback(rollback),
        .issue_enable(issue_enable), .issue_op(issue_op),
        .issue_Vj(issue_Vj), .issue_Vk(issue_Vk), .issue_Rj(issue_Rj), .issue_Rk(issue_Rk),
        .issue_Qj(issue_Qj), .issue_Qk(issue_Qk), .issue_Imm(issue_Imm),
        .issue_CurPc(issue_CurPc), .issue_RobId(issue_RobId), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_RobId(alu_cdb_RobId), .alu_cdb_value(alu_cdb_value),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_RobId(lsb_cdb_RobId), .lsb_cdb_value(lsb_cdb_value),
        .exec_valid(exec_valid), .exec_op(exec_op), .exec_Vj(exec_Vj), .exec_Vk(exec_Vk),
        .exec_Imm(exec_Imm), .exec_CurPc(exec_CurPc), .exec_RobId(exec_RobId)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        en;
        logic        rj;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic        rk;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic [3:0]  rob;
        logic        acv;
        logic [3:0]  act;
        logic [31:0] acval;
        logic        lcv;
        logic [3:0]  lct;
        logic [31:0] lcval;
        logic        ev;
        logic [31:0] evj;
        logic [31:0] evk;
        logic [3:0]  erob;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic en, input logic rj, input logic [31:0] vj,
                                input logic [3:0] qj, input logic rk, input logic [31:0] vk,
                                input logic [3:0] qk, input logic [3:0] rob,
                                input logic acv, input logic [3:0] act, input logic [31:0] acval,
                                input logic lcv, input logic [3:0] lct, input logic [31:0] lcval,
                                input logic ev, input logic [31:0] evj, input logic [31:0] evk,
                                input logic [3:0] erob);
        vec_t v;
        v.en = en; v.rj = rj; v.vj = vj; v.qj = qj; v.rk = rk; v.vk = vk; v.qk = qk; v.rob = rob;
        v.acv = acv; v.act = act; v.acval = acval; v.lcv = lcv; v.lct = lct; v.lcval = lcval;
        v.ev = ev; v.evj = evj; v.evk = evk; v.erob = erob;
        tbl.push_back(v);
    endfunction

    function automatic void idle_row(input logic ev, input logic [31:0] evj,
                                     input logic [31:0] evk, input logic [3:0] erob);
        add(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0,
            1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, ev, evj, evk, erob);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Full dispatch bundle check; op/Imm/PC are derived from the ROB tag.
    task automatic chk_disp(input string name, input logic [31:0] evj,
                            input logic [31:0] evk, input logic [3:0] erob);
        chk({name, " valid"}, {31'h0, exec_valid}, 32'h1);
        chk({name, " Vj"}, exec_Vj, evj);
        chk({name, " Vk"}, exec_Vk, evk);
        chk({name, " RobId"}, {28'h0, exec_RobId}, {28'h0, erob});
        chk({name, " op"}, {26'h0, exec_op}, {26'h0, 2'b01, erob});
        chk({name, " Imm"}, exec_Imm, 32'h0000_1000 + {28'h0, erob});
        chk({name, " PC"}, exec_CurPc, 32'h8000_0000 + {26'h0, erob, 2'b00});
    endtask

    task automatic idle_in();
        rdy_in = 1'b1; rollback = 1'b0; issue_enable = 1'b0;
        issue_op = 6'h0; issue_Vj = 32'h0; issue_Vk = 32'h0;
        issue_Rj = 1'b0; issue_Rk = 1'b0; issue_Qj = 4'h0; issue_Qk = 4'h0;
        issue_Imm = 32'h0; issue_CurPc = 32'h0; issue_RobId = 4'h0;
        alu_cdb_valid = 1'b0; alu_cdb_RobId = 4'h0; alu_cdb_value = 32'h0;
        lsb_cdb_valid = 1'b0; lsb_cdb_RobId = 4'h0; lsb_cdb_value = 32'h0;
    endtask

    task automatic drive_issue(input logic en, input logic rj, input logic [31:0] vj,
                               input logic [3:0] qj, input logic rk, input logic [31:0] vk,
                               input logic [3:0] qk, input logic [3:0] rob);
        issue_enable = en; issue_Rj = rj; issue_Vj = vj; issue_Qj = qj;
        issue_Rk = rk; issue_Vk = vk; issue_Qk = qk; issue_RobId = rob;
        issue_op = {2'b01, rob};
        issue_Imm = 32'h0000_1000 + {28'h0, rob};
        issue_CurPc = 32'h8000_0000 + {26'h0, rob, 2'b00};
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table ----------------
        // ready insert -> dispatch one edge later
        add(1'b1, 1'b1, 32'd5, 4'h0, 1'b1, 32'd7, 4'h0, 4'd3, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b1, 32'd5, 32'd7, 4'd3);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);
        // wakeup through ALU CDB two cycles after insert
        add(1'b1, 1'b0, 32'h0, 4'd2, 1'b1, 32'd11, 4'h0, 4'd4, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);
        add(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 4'd2, 32'hDEAD, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b1, 32'hDEAD, 32'd11, 4'd4);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);
        // same-cycle forwarding from LSB CDB on k
        add(1'b1, 1'b1, 32'd1, 4'h0, 1'b0, 32'h0, 4'd6, 4'd5, 1'b0, 4'h0, 32'h0, 1'b1, 4'd6, 32'd9, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b1, 32'd1, 32'd9, 4'd5);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);
        // forwarding on both operands from both buses
        add(1'b1, 1'b0, 32'h0, 4'd7, 1'b0, 32'h0, 4'd8, 4'd6, 1'b1, 4'd7, 32'h70, 1'b1, 4'd8, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b1, 32'h70, 32'h80, 4'd6);
        // back-to-back dispatch, one per cycle
        add(1'b1, 1'b1, 32'hA1, 4'h0, 1'b1, 32'hA2, 4'h0, 4'd7, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        add(1'b1, 1'b1, 32'hB1, 4'h0, 1'b1, 32'hB2, 4'h0, 4'd8, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'hA1, 32'hA2, 4'd7);
        idle_row(1'b1, 32'hB1, 32'hB2, 4'd8);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);
        // non-matching tag must not wake; matching LSB tag does
        add(1'b1, 1'b0, 32'h0, 4'd9, 1'b1, 32'h33, 4'h0, 4'd9, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        add(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 4'd10, 32'h55, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        add(1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'd9, 32'h99, 1'b0, 32'h0, 32'h0, 4'h0);
        idle_row(1'b1, 32'h99, 32'h33, 4'd9);
        idle_row(1'b0, 32'h0, 32'h0, 4'h0);

        // ---------------- reset state ----------------
        idle_in();
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset exec_valid", {31'h0, exec_valid}, 32'h0);
        chk("reset rs_full", {31'h0, rs_full}, 32'h0);
        chk("reset exec_Vj", exec_Vj, 32'h0);
        chk("reset exec_RobId", {28'h0, exec_RobId}, 32'h0);
        #2;
        rst_n_in = 1'b1;
        step();

        // ---------------- apply table ----------------
        for (int k = 0; k < tbl.size(); k++) begin
            idle_in();
            drive_issue(tbl[k].en, tbl[k].rj, tbl[k].vj, tbl[k].qj,
                        tbl[k].rk, tbl[k].vk, tbl[k].qk, tbl[k].rob);
            alu_cdb_valid = tbl[k].acv; alu_cdb_RobId = tbl[k].act; alu_cdb_value = tbl[k].acval;
            lsb_cdb_valid = tbl[k].lcv; lsb_cdb_RobId = tbl[k].lct; lsb_cdb_value = tbl[k].lcval;
            step();
            if (tbl[k].ev) begin
                chk_disp($sformatf("tbl%0d", k), tbl[k].evj, tbl[k].evk, tbl[k].erob);
            end else begin
                chk($sformatf("tbl%0d valid", k), {31'h0, exec_valid}, 32'h0);
            end
            chk($sformatf("tbl%0d rs_full", k), {31'h0, rs_full}, 32'h0);
        end

        // ---------------- fill to 15 and ordering ----------------
        for (int i = 0; i < 15; i++) begin
            idle_in();
            drive_issue(1'b1, 1'b0, 32'h0, (i == 4 || i == 9) ? 4'd12 : 4'd14,
                        1'b1, 32'h100 + i, 4'h0, 4'(i));
            step();
            chk($sformatf("fill%0d rs_full", i), {31'h0, rs_full}, (i >= 14) ? 32'h1 : 32'h0);
            chk($sformatf("fill%0d valid", i), {31'h0, exec_valid}, 32'h0);
        end
        idle_in();
        alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd12; alu_cdb_value = 32'h1200;
        step();
        chk("wake12 valid", {31'h0, exec_valid}, 32'h0);
        chk("wake12 rs_full", {31'h0, rs_full}, 32'h1);
        idle_in();
        step();
        chk_disp("slot4", 32'h1200, 32'h104, 4'd4);
        chk("slot4 rs_full", {31'h0, rs_full}, 32'h0);
        step();
        chk_disp("slot9", 32'h1200, 32'h109, 4'd9);
        chk("slot9 rs_full", {31'h0, rs_full}, 32'h0);
        lsb_cdb_valid = 1'b1; lsb_cdb_RobId = 4'd14; lsb_cdb_value = 32'h1400;
        step();
        chk("wake14 valid", {31'h0, exec_valid}, 32'h0);
        idle_in();
        for (int s = 0; s < 15; s++) begin
            if (s == 4 || s == 9) continue;
            step();
            chk_disp($sformatf("drain%0d", s), 32'h1400, 32'h100 + s, 4'(s));
        end
        step();
        chk("drained valid", {31'h0, exec_valid}, 32'h0);

        // ---------------- rollback ----------------
        idle_in();
        drive_issue(1'b1, 1'b0, 32'h0, 4'd3, 1'b1, 32'h21, 4'h0, 4'd2);
        step();
        idle_in();
        drive_issue(1'b1, 1'b1, 32'h11, 4'h0, 1'b1, 32'h12, 4'h0, 4'd1);
        step();
        chk("rb pre valid", {31'h0, exec_valid}, 32'h0);
        idle_in();
        drive_issue(1'b1, 1'b1, 32'hA0, 4'h0, 1'b1, 32'hA0, 4'h0, 4'd10);
        rollback = 1'b1;
        step();
        chk("rb edge valid", {31'h0, exec_valid}, 32'h0);
        chk("rb edge rs_full", {31'h0, rs_full}, 32'h0);
        idle_in();
        step();
        chk("rb after valid", {31'h0, exec_valid}, 32'h0);
        alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd3; alu_cdb_value = 32'h3;
        step();
        idle_in();
        step();
        chk("rb old tag valid", {31'h0, exec_valid}, 32'h0);

        // ---------------- rdy_in hold ----------------
        drive_issue(1'b1, 1'b1, 32'h51, 4'h0, 1'b1, 32'h52, 4'h0, 4'd5);
        step();
        idle_in();
        rdy_in = 1'b0;
        step();
        chk("hold0 valid", {31'h0, exec_valid}, 32'h0);
        rdy_in = 1'b1;
        step();
        chk_disp("hold dispatch", 32'h51, 32'h52, 4'd5);
        rdy_in = 1'b0;
        step();
        chk("hold1 valid", {31'h0, exec_valid}, 32'h1);
        rdy_in = 1'b1;
        step();
        chk("hold release valid", {31'h0, exec_valid}, 32'h0);

        // ---------------- async reset mid-operation ----------------
        idle_in();
        drive_issue(1'b1, 1'b0, 32'h0, 4'd5, 1'b1, 32'h1, 4'h0, 4'd1);
        step();
        drive_issue(1'b1, 1'b0, 32'h0, 4'd5, 1'b1, 32'h2, 4'h0, 4'd2);
        step();
        drive_issue(1'b1, 1'b1, 32'hC1, 4'h0, 1'b1, 32'hC2, 4'h0, 4'd3);
        step();
        idle_in();
        step();
        chk_disp("pre-reset", 32'hC1, 32'hC2, 4'd3);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async rst valid", {31'h0, exec_valid}, 32'h0);
        chk("async rst Vj", exec_Vj, 32'h0);
        chk("async rst RobId", {28'h0, exec_RobId}, 32'h0);
        chk("async rst rs_full", {31'h0, rs_full}, 32'h0);
        #1;
        rst_n_in = 1'b1;
        alu_cdb_valid = 1'b1; alu_cdb_RobId = 4'd5; alu_cdb_value = 32'h5;
        step();
        idle_in();
        chk("post rst wake valid", {31'h0, exec_valid}, 32'h0);
        step();
        chk("post rst idle valid", {31'h0, exec_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
